// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
package mips_pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One fetched instruction as held between IF and ID; pc occupies the upper bits.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_entry_t;

endpackage : mips_pipe_pkg

// File: rtl/ifq_storage.sv
// Register-array storage for the fetch hold queue: one write port, one async read port.
module ifq_storage #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Data slots carry no reset; validity is tracked by the owner's occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr];

endmodule : ifq_storage

// File: rtl/if_stall_hold_queue.sv
// IF->ID hold queue: buffers fetched {pc, instr}, freezes head on load-use stall,
// drops everything on flush, shows NOP when empty and tracks stall duration.
module if_stall_hold_queue #(
    parameter int unsigned INSTR_W     = mips_pipe_pkg::INSTR_W,
    parameter int unsigned PC_W        = mips_pipe_pkg::PC_W,
    parameter int unsigned DEPTH       = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR,
    parameter int unsigned STALL_MAX   = 8,
    parameter int unsigned STALL_CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     lw_use_control_stall,
    input  logic                     flush,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     stall_timeout
);

    import mips_pipe_pkg::*;

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned OCC_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = PC_W + INSTR_W;

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   stall_timeout_q, stall_timeout_d;
    logic                   push, pop;
    logic [ENTRY_W-1:0]     head_entry;

    // Readiness and head visibility come from registered occupancy only.
    assign in_ready  = (occ_q != OCC_W'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign out_pc    = out_valid ? head_entry[ENTRY_W-1:INSTR_W] : '0;
    assign out_instr = out_valid ? head_entry[INSTR_W-1:0]       : NOP_INSTR;
    assign occupancy = occ_q;
    assign stall_timeout = stall_timeout_q;

    ifq_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (wr_ptr_q),
        .wr_data ({in_pc, in_instr}),
        .rd_ptr  (rd_ptr_q),
        .rd_data (head_entry)
    );

    // Next-state: flush dominates, otherwise independent push/pop and stall counting.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        occ_d           = occ_q;
        stall_cnt_d     = '0;
        stall_timeout_d = 1'b0;
        push            = in_valid & in_ready & ~flush;
        pop             = out_valid & ~lw_use_control_stall & ~flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (pop && !push) begin
                occ_d = occ_q - OCC_W'(1);
            end
            if (lw_use_control_stall) begin
                stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + STALL_CNT_W'(1);
            end
        end

        stall_timeout_d = (stall_cnt_d >= STALL_CNT_W'(STALL_MAX));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

endmodule : if_stall_hold_queue

// File: tb/tb_if_stall_hold_queue.sv
// Directed bench for if_stall_hold_queue with hand-computed expectations.
module tb_if_stall_hold_queue;

    logic        clk;
    logic        rst;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_valid;
    logic        in_ready;
    logic        lw_use_control_stall;
    logic        flush;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_valid;
    logic [2:0]  occupancy;
    logic        stall_timeout;

    int n_vec;
    int n_err;

    if_stall_hold_queue dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_instr             (in_instr),
        .in_pc                (in_pc),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .lw_use_control_stall (lw_use_control_stall),
        .flush                (flush),
        .out_instr            (out_instr),
        .out_pc               (out_pc),
        .out_valid            (out_valid),
        .occupancy            (occupancy),
        .stall_timeout        (stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_pc    = '0;
        in_instr = '0;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_instr"}, 64'(out_instr), 64'h0);
        chk({tag, "_pc"},    64'(out_pc),    64'h0);
        chk({tag, "_occ"},   64'(occupancy), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready),  64'd1);
    endtask

    logic [31:0] held_instr;
    logic [31:0] held_pc;

    initial begin
        clk = 1'b0;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        flush = 1'b0;
        lw_use_control_stall = 1'b0;
        idle_in();
        step();
        step();
        rst = 1'b0;

        // Reset and idle
        step();
        chk_empty("reset");
        chk("reset_tmo", 64'(stall_timeout), 64'd0);

        // Back-to-back pushes without stall
        offer(32'h0, 32'h8C22_0004);
        step();
        chk("b2b_c2_instr", 64'(out_instr), 64'h8C22_0004);
        chk("b2b_c2_pc",    64'(out_pc),    64'h0);
        chk("b2b_c2_occ",   64'(occupancy), 64'd1);
        offer(32'h4, 32'h0043_2020);
        step();
        chk("b2b_c3_instr", 64'(out_instr), 64'h0043_2020);
        chk("b2b_c3_pc",    64'(out_pc),    64'h4);
        chk("b2b_c3_occ",   64'(occupancy), 64'd1);
        idle_in();
        step();
        chk_empty("b2b_drain");

        // Fill four entries under stall; pointers start at slot 2 so writes wrap
        lw_use_control_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            offer(32'h100 + 32'(4 * k), 32'h1111_1111 * 32'(k));
            step();
            chk("fill_occ", 64'(occupancy), 64'(k));
        end
        chk("fill_ready", 64'(in_ready), 64'd0);
        offer(32'h200, 32'hDEAD_BEEF);
        step();
        chk("fill_5th_occ",   64'(occupancy), 64'd4);
        chk("fill_5th_head",  64'(out_instr), 64'h1111_1111);
        chk("fill_tmo",       64'(stall_timeout), 64'd0);

        // Release stall and drain in FIFO order
        lw_use_control_stall = 1'b0;
        idle_in();
        for (int k = 1; k <= 4; k++) begin
            chk("drain_instr", 64'(out_instr), 64'(32'h1111_1111 * 32'(k)));
            chk("drain_pc",    64'(out_pc),    64'(32'h100 + 32'(4 * k)));
            step();
        end
        chk_empty("drain_end");

        // Two entries, stall holds head steady
        lw_use_control_stall = 1'b1;
        offer(32'h40, 32'hAAAA_0001);
        step();
        offer(32'h44, 32'hAAAA_0002);
        step();
        idle_in();
        chk("hold_occ", 64'(occupancy), 64'd2);
        held_instr = 32'hAAAA_0001;
        held_pc    = 32'h40;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_instr", 64'(out_instr), 64'(held_instr));
            chk("hold_pc",    64'(out_pc),    64'(held_pc));
            chk("hold_occ2",  64'(occupancy), 64'd2);
        end
        lw_use_control_stall = 1'b0;
        step();
        chk("rel_instr", 64'(out_instr), 64'hAAAA_0002);
        chk("rel_pc",    64'(out_pc),    64'h44);
        chk("rel_occ",   64'(occupancy), 64'd1);
        step();
        chk_empty("rel_end");

        // Flush with push and stall in the same cycle
        lw_use_control_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            offer(32'h80 + 32'(4 * k), 32'hBBBB_0000 + 32'(k));
            step();
        end
        chk("pre_flush_occ", 64'(occupancy), 64'd3);
        offer(32'h8C, 32'hBBBB_0003);
        flush = 1'b1;
        step();
        flush = 1'b0;
        lw_use_control_stall = 1'b0;
        idle_in();
        chk_empty("flush");
        chk("flush_cnt", 64'(dut.stall_cnt_q), 64'd0);
        step();
        chk_empty("post_flush");

        // Stall timeout: counter reaches 8 after the 8th stall cycle
        lw_use_control_stall = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("tmo_rise", 64'(stall_timeout), (k >= 8) ? 64'd1 : 64'd0);
        end
        lw_use_control_stall = 1'b0;
        chk("tmo_hold", 64'(stall_timeout), 64'd1);
        step();
        chk("tmo_clear", 64'(stall_timeout), 64'd0);

        // Reset while full and stalled
        lw_use_control_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(32'hC0 + 32'(4 * k), 32'hCCCC_0000 + 32'(k));
            step();
        end
        chk("rst_full_occ", 64'(occupancy), 64'd4);
        rst = 1'b1;
        step();
        chk_empty("midrst");
        chk("midrst_tmo", 64'(stall_timeout), 64'd0);
        rst = 1'b0;
        lw_use_control_stall = 1'b0;
        idle_in();
        step();
        chk_empty("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_if_stall_hold_queue
